if_buf_responder: RTL and testbench

- Input-feature buffer that sits on the responder side of the `if_fifo_ctrl` / `if_fifo_resp` handshake issued by the PE-array control FSM.
- On a load request it fills DEPTH words from SRAM and reports full.
- On a drain request it streams the words to the PE input register files with valid/ready, then reports empty.
- One instance per feature buffer, between the SRAM read port and the PE array.

---
 rtl/if_buf_responder.sv | 215 +++++++++++++++++++++
 tb/tb_if_buf_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_buf_responder.sv
`default_nettype none
// ============================================================================
// Module   : if_buf_responder
// Purpose  : Input-feature buffer on the responder side of the
//            fifo_ctrl / fifo_resp handshake. A load request fills DEPTH
//            words from SRAM and reports full. A drain request streams the
//            words to the PE array with valid/ready and then reports empty.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            fifo_ctrl[1:0]      - [0] load request, [1] drain request
//            fifo_resp[1:0]      - [0] full, [1] drained (registered)
//            sram_base_addr      - first SRAM word of a load
//            sram_rd_en/addr     - SRAM read port (registered)
//            sram_rd_data        - SRAM data, one cycle after sram_rd_en
//            pe_wr_valid/ready   - handshake towards the PE array
//            pe_wr_data          - word presented to the PE array
//            count               - words currently held
// Options  : IF_BUF_REPLAY_EN    - DONE returns to FULL with contents kept,
//                                  so the same words can be drained again;
//                                  a load request in FULL starts a reload.
// Revision : 1.0 - initial release
// ============================================================================
module if_buf_responder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 25,
    parameter int ADDR_W = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     fifo_ctrl,
    output logic [1:0]                     fifo_resp,
    input  logic [ADDR_W-1:0]              sram_base_addr,
    output logic                           sram_rd_en,
    output logic [ADDR_W-1:0]              sram_rd_addr,
    input  logic [DATA_W-1:0]              sram_rd_data,
    output logic                           pe_wr_valid,
    input  logic                           pe_wr_ready,
    output logic [DATA_W-1:0]              pe_wr_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_FULL  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [CNT_W-1:0]    issue_q,   issue_d;    // SRAM reads issued this load
    logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
    logic                rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_vld_q,  rd_vld_d;   // sram_rd_data carries a word
    logic [1:0]          resp_q,    resp_d;

    logic                w_start_load;
    logic                w_mem_we;
    logic                w_xfer;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign fifo_resp    = resp_q;
    assign sram_rd_en   = rd_en_q;
    assign sram_rd_addr = rd_addr_q;
    assign count        = cnt_q;

    assign pe_wr_valid  = (state_q == S_DRAIN) && fifo_ctrl[1] && (cnt_q != '0);
    assign pe_wr_data   = (state_q == S_DRAIN) ? mem_q[rd_ptr_q] : '0;
    assign w_xfer       = pe_wr_valid && pe_wr_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        issue_d      = issue_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = '0;
        rd_vld_d     = 1'b0;
        w_start_load = 1'b0;
        w_mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifo_ctrl[0]) begin
                    w_start_load = 1'b1;
                end
            end

            S_FILL: begin
                if (!fifo_ctrl[0]) begin
                    // Abort: the word still in flight is dropped because
                    // rd_vld is cleared and IDLE never writes storage.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    issue_d = '0;
                end else begin
                    if (issue_q != CNT_FULL) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        issue_d   = issue_q + CNT_W'(1);
                    end
                    rd_vld_d = rd_en_q;
                    if (rd_vld_q) begin
                        w_mem_we = 1'b1;
                        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_FULL) begin
                        state_d = S_FULL;
                    end
                end
            end

            S_FULL: begin
`ifdef IF_BUF_REPLAY_EN
                if (fifo_ctrl[0]) begin
                    w_start_load = 1'b1;
                end else if (fifo_ctrl[1]) begin
                    state_d = S_DRAIN;
                end
`else
                if (fifo_ctrl[1]) begin
                    state_d = S_DRAIN;
                end
`endif
            end

            S_DRAIN: begin
                if (w_xfer) begin
                    rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (!fifo_ctrl[1]) begin
`ifdef IF_BUF_REPLAY_EN
                    state_d  = S_FULL;
                    rd_ptr_d = '0;
                    cnt_d    = CNT_FULL;
`else
                    state_d  = S_IDLE;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_start_load) begin
            state_d   = S_FILL;
            rd_en_d   = 1'b1;
            rd_addr_d = sram_base_addr;
            issue_d   = CNT_W'(1);
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
        end

        // Response levels follow the state being entered so they are
        // registered and change on the same edge as the state.
        case (state_d)
            S_FULL:  resp_d = 2'b01;
            S_DONE:  resp_d = 2'b10;
            default: resp_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            issue_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            issue_q   <= issue_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_vld_q  <= rd_vld_d;
            resp_q    <= resp_d;
        end
    end

    // Storage has no reset; its contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wr_ptr_q] <= sram_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_buf_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_buf_responder
// Purpose  : Self-checking bench for if_buf_responder (DEPTH=25, ADDR_W=10,
//            DATA_W=16) with a behavioural one-cycle-latency SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_buf_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fifo_ctrl;
    logic [1:0]  fifo_resp;
    logic [9:0]  sram_base_addr;
    logic        sram_rd_en;
    logic [9:0]  sram_rd_addr;
    logic [15:0] sram_rd_data;
    logic        pe_wr_valid;
    logic        pe_wr_ready;
    logic [15:0] pe_wr_data;
    logic [4:0]  count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    if_buf_responder #(.DATA_W(16), .DEPTH(25), .ADDR_W(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_ctrl      (fifo_ctrl),
        .fifo_resp      (fifo_resp),
        .sram_base_addr (sram_base_addr),
        .sram_rd_en     (sram_rd_en),
        .sram_rd_addr   (sram_rd_addr),
        .sram_rd_data   (sram_rd_data),
        .pe_wr_valid    (pe_wr_valid),
        .pe_wr_ready    (pe_wr_ready),
        .pe_wr_data     (pe_wr_data),
        .count          (count)
    );

    always #5 clk = ~clk;

    // SRAM content pattern: unique per address
    function automatic logic [15:0] sram_word(input logic [9:0] a);
        return {a[5:0], a} ^ 16'h5A3C;
    endfunction

    always @(posedge clk) begin
        sram_rd_data <= sram_rd_en ? sram_word(sram_rd_addr) : 16'hDEAD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load from base; checks address sequence, read timing, full latency.
    task automatic load(input logic [9:0] base);
        int rise;
        int nrd;
        logic [9:0] ea;
        rise = -1;
        nrd  = 0;
        sram_base_addr = base;
        fifo_ctrl      = 2'b01;
        step();                                   // FILL entry edge
        for (int k = 0; k < 40 && rise < 0; k++) begin
            if (sram_rd_en) begin
                ea = base + 10'(nrd);
                chk("rd_addr", 32'(sram_rd_addr), 32'(ea));
                chk("rd_cycle", k, nrd);
                nrd++;
            end
            if (fifo_resp == 2'b01) begin
                rise = k;
                fifo_ctrl = 2'b00;
            end else begin
                step();
            end
        end
        chk("resp_full_latency", rise, 27);
        chk("n_reads", nrd, 25);
        chk("count_full", 32'(count), 25);
    endtask

    // Drain from FULL. stop_cnt >= 0 stops early when count hits it.
    task automatic drain(input logic [9:0] base, input bit stall, input int stop_cnt);
        int n;
        int c;
        bit held_v;
        logic [15:0] held;
        logic [9:0] ea;
        n      = 0;
        held_v = 1'b0;
        held   = '0;
        fifo_ctrl   = 2'b10;
        pe_wr_ready = 1'b1;
        step();                                   // DRAIN entry edge
        chk("resp_drain_entry", 32'(fifo_resp), 0);
        for (c = 0; c < 120; c++) begin
            if (n == 25) break;
            if (stop_cnt >= 0 && int'(count) == stop_cnt) break;
            pe_wr_ready = stall ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            if (held_v) begin
                chk("stall_hold", {15'd0, pe_wr_valid, pe_wr_data}, {15'd0, 1'b1, held});
            end
            if (pe_wr_valid && pe_wr_ready) begin
                ea = base + 10'(n);
                chk("drain_data", 32'(pe_wr_data), 32'(sram_word(ea)));
                n++;
                held_v = 1'b0;
            end else if (pe_wr_valid) begin
                held   = pe_wr_data;
                held_v = 1'b1;
            end
            step();
        end
        if (stop_cnt < 0) begin
            chk("n_transfers", n, 25);
            if (!stall) chk("drain_cycles", c, 25);
            chk("resp_done", 32'(fifo_resp), 2);
            chk("count_empty", 32'(count), 0);
            chk("valid_done", 32'(pe_wr_valid), 0);
        end else begin
            chk("count_stop", 32'(count), 32'(stop_cnt));
        end
    endtask

    typedef struct {
        logic [1:0] ctrl;
        logic [1:0] resp;
        logic       rd_en;
        logic [9:0] addr;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int nrd;

        tbl[0] = '{ctrl: 2'b00, resp: 2'b00, rd_en: 1'b0, addr: 10'h000, cnt: 5'd0};
        tbl[1] = '{ctrl: 2'b10, resp: 2'b00, rd_en: 1'b0, addr: 10'h000, cnt: 5'd0};  // drain alone ignored
        tbl[2] = '{ctrl: 2'b11, resp: 2'b00, rd_en: 1'b1, addr: 10'h010, cnt: 5'd0};  // load has priority
        tbl[3] = '{ctrl: 2'b01, resp: 2'b00, rd_en: 1'b1, addr: 10'h011, cnt: 5'd0};
        tbl[4] = '{ctrl: 2'b01, resp: 2'b00, rd_en: 1'b1, addr: 10'h012, cnt: 5'd1};
        tbl[5] = '{ctrl: 2'b01, resp: 2'b00, rd_en: 1'b1, addr: 10'h013, cnt: 5'd2};
        tbl[6] = '{ctrl: 2'b00, resp: 2'b00, rd_en: 1'b0, addr: 10'h000, cnt: 5'd0};  // abort
        tbl[7] = '{ctrl: 2'b10, resp: 2'b00, rd_en: 1'b0, addr: 10'h000, cnt: 5'd0};

        rst            = 1'b1;
        fifo_ctrl      = 2'b00;
        sram_base_addr = 10'h010;
        pe_wr_ready    = 1'b0;
        step();
        step();
        chk("rst_resp",  32'(fifo_resp), 0);
        chk("rst_rd_en", 32'(sram_rd_en), 0);
        chk("rst_addr",  32'(sram_rd_addr), 0);
        chk("rst_valid", 32'(pe_wr_valid), 0);
        chk("rst_data",  32'(pe_wr_data), 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            fifo_ctrl = tbl[i].ctrl;
            step();
            chk($sformatf("vec%0d_resp", i),  32'(fifo_resp),    32'(tbl[i].resp));
            chk($sformatf("vec%0d_rd_en", i), 32'(sram_rd_en),   32'(tbl[i].rd_en));
            chk($sformatf("vec%0d_addr", i),  32'(sram_rd_addr), 32'(tbl[i].addr));
            chk($sformatf("vec%0d_count", i), 32'(count),        32'(tbl[i].cnt));
            chk($sformatf("vec%0d_valid", i), 32'(pe_wr_valid),  0);
        end

        // Full load then drain at full rate
        load(10'h010);
        drain(10'h010, 1'b0, -1);
        fifo_ctrl = 2'b00;
        step();
`ifdef IF_BUF_REPLAY_EN
        chk("replay_resp",  32'(fifo_resp), 1);
        chk("replay_count", 32'(count), 25);
        drain(10'h010, 1'b0, -1);
        fifo_ctrl = 2'b00;
        step();
        chk("replay2_resp", 32'(fifo_resp), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`else
        chk("idle_resp",  32'(fifo_resp), 0);
        chk("idle_count", 32'(count), 0);
`endif

        // Drain with ready pattern 1,0,0,1
        load(10'h010);
        drain(10'h010, 1'b1, -1);
        fifo_ctrl = 2'b00;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Abort after 10 reads
        sram_base_addr = 10'h200;
        fifo_ctrl      = 2'b01;
        step();
        nrd = 0;
        for (int k = 0; k < 20; k++) begin
            if (sram_rd_en) nrd++;
            if (nrd == 10) break;
            step();
        end
        chk("abort_reads", nrd, 10);
        fifo_ctrl = 2'b00;
        step();
        chk("abort_rd_en", 32'(sram_rd_en), 0);
        chk("abort_resp",  32'(fifo_resp), 0);
        chk("abort_count", 32'(count), 0);
        step();
        chk("abort_count2", 32'(count), 0);

        // Wrapping load, then reset mid-drain at count 12
        load(10'h3F8);
        drain(10'h3F8, 1'b0, 12);
        rst = 1'b1;
        step();
        chk("mid_rst_resp",  32'(fifo_resp), 0);
        chk("mid_rst_rd_en", 32'(sram_rd_en), 0);
        chk("mid_rst_addr",  32'(sram_rd_addr), 0);
        chk("mid_rst_valid", 32'(pe_wr_valid), 0);
        chk("mid_rst_data",  32'(pe_wr_data), 0);
        chk("mid_rst_count", 32'(count), 0);
        rst       = 1'b0;
        fifo_ctrl = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_ignore_resp",  32'(fifo_resp), 0);
            chk("idle_ignore_valid", 32'(pe_wr_valid), 0);
            chk("idle_ignore_rd_en", 32'(sram_rd_en), 0);
        end
        fifo_ctrl = 2'b00;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
